// File: rtl/fwd_pkg.sv
// -----------------------------------------------------------------------------
// fwd_pkg
// Shared types and constants for the forwarding/hazard unit.
//   - XLEN_DEF / RA_W_DEF : default data and register-address widths
//   - src_sel_e           : which source feeds a forwarded operand
//   - entry_t             : layout of one in-flight scoreboard entry
//                           (sized for the default widths)
// -----------------------------------------------------------------------------
package fwd_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RA_W_DEF = 5;

  // Operand source selected by a lookup.
  typedef enum logic [1:0] {
    SRC_RF    = 2'd0,  // register-file read data (no producer in flight)
    SRC_ALU   = 2'd1,  // result of the instruction currently in EX
    SRC_MEM   = 2'd2,  // load data of the instruction currently in MEM
    SRC_ENTRY = 2'd3   // value already captured in a scoreboard entry
  } src_sel_e;

  typedef struct packed {
    logic                vld;
    logic [RA_W_DEF-1:0] rd;
    logic                ld;
    logic [XLEN_DEF-1:0] data;
  } entry_t;

endpackage

// File: rtl/fwd_scoreboard_if.sv
// -----------------------------------------------------------------------------
// fwd_scoreboard_if
// Groups the issue, operand and status signals of fwd_scoreboard.
//   master : pipeline side (drives issue/operand inputs, reads results)
//   slave  : the forwarding unit itself
// Signal names keep the unit's _i/_o direction suffixes as seen by the unit.
// -----------------------------------------------------------------------------
interface fwd_scoreboard_if
  import fwd_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RA_W  = RA_W_DEF,
  parameter int NSRC  = 2,
  parameter int CNT_W = 16
);

  logic                 hold_i;
  logic                 flush_i;
  logic                 issue_valid_i;
  logic [RA_W-1:0]      issue_rd_i;
  logic                 issue_we_i;
  logic                 issue_is_load_i;
  logic [NSRC*RA_W-1:0] rs_i;
  logic [NSRC*XLEN-1:0] rf_data_i;
  logic [XLEN-1:0]      alu_result_i;
  logic [XLEN-1:0]      mem_rdata_i;
  logic [NSRC*XLEN-1:0] opnd_o;
  logic [NSRC-1:0]      fwd_hit_o;
  logic                 stall_o;
  logic [CNT_W-1:0]     stall_cnt_o;

  modport master (
    output hold_i, flush_i, issue_valid_i, issue_rd_i, issue_we_i,
           issue_is_load_i, rs_i, rf_data_i, alu_result_i, mem_rdata_i,
    input  opnd_o, fwd_hit_o, stall_o, stall_cnt_o
  );

  modport slave (
    input  hold_i, flush_i, issue_valid_i, issue_rd_i, issue_we_i,
           issue_is_load_i, rs_i, rf_data_i, alu_result_i, mem_rdata_i,
    output opnd_o, fwd_hit_o, stall_o, stall_cnt_o
  );

endinterface

// File: rtl/fwd_lookup.sv
// -----------------------------------------------------------------------------
// fwd_lookup
// Combinational priority scan for one source operand. The youngest valid
// entry whose rd matches i_rs supplies the operand; x0 never matches.
//   i_rs          source register address
//   i_rf_data     register-file value (fallback)
//   i_alu_result  result of the E0 instruction
//   i_mem_rdata   load data of the E1 instruction
//   i_vld/i_rd    valid bits and destinations of E0..E[DEPTH-1]
//   i_ld          is-load bits of E0 and E1
//   i_data        captured data of E1..E[DEPTH-1]
//   o_opnd        selected operand
//   o_hit         operand came from an in-flight producer
//   o_stall       producer is a load still in EX
// -----------------------------------------------------------------------------
module fwd_lookup
  import fwd_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RA_W  = RA_W_DEF,
  parameter int DEPTH = 3
) (
  input  logic [RA_W-1:0]           i_rs,
  input  logic [XLEN-1:0]           i_rf_data,
  input  logic [XLEN-1:0]           i_alu_result,
  input  logic [XLEN-1:0]           i_mem_rdata,
  input  logic [DEPTH-1:0]          i_vld,
  input  logic [DEPTH*RA_W-1:0]     i_rd,
  input  logic [1:0]                i_ld,
  input  logic [(DEPTH-1)*XLEN-1:0] i_data,
  output logic [XLEN-1:0]           o_opnd,
  output logic                      o_hit,
  output logic                      o_stall
);

  localparam int IDX_W = $clog2(DEPTH);

  logic             w_found;
  logic [IDX_W-1:0] w_idx;
  logic [XLEN-1:0]  w_ent_data;
  src_sel_e         w_sel;

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (i_vld[k] && (i_rd[k*RA_W +: RA_W] == i_rs)) begin
        w_found = 1'b1;
        w_idx   = IDX_W'(k);
      end
    end
  end

  // Captured data of the winning entry (E0 never holds a usable value).
  always_comb begin
    w_ent_data = '0;
    for (int k = 1; k < DEPTH; k++) begin
      if (w_idx == IDX_W'(k)) w_ent_data = i_data[(k-1)*XLEN +: XLEN];
    end
  end

  always_comb begin
    w_sel   = SRC_RF;
    o_stall = 1'b0;
    if ((i_rs != '0) && w_found) begin
      if (w_idx == '0) begin
        // A load in EX has no data yet: stall rather than forward.
        if (i_ld[0]) o_stall = 1'b1;
        else         w_sel   = SRC_ALU;
      end else if ((w_idx == IDX_W'(1)) && i_ld[1]) begin
        w_sel = SRC_MEM;
      end else begin
        w_sel = SRC_ENTRY;
      end
    end
  end

  always_comb begin
    case (w_sel)
      SRC_ALU:   o_opnd = i_alu_result;
      SRC_MEM:   o_opnd = i_mem_rdata;
      SRC_ENTRY: o_opnd = w_ent_data;
      default:   o_opnd = i_rf_data;
    endcase
  end

  assign o_hit = (w_sel != SRC_RF);

endmodule

// File: rtl/fwd_scoreboard.sv
// -----------------------------------------------------------------------------
// fwd_scoreboard
// Forwarding and load-use hazard unit. A shift-register scoreboard tracks
// every in-flight register write from EX (E0) through the last writeback
// stage; each source operand is resolved by its own fwd_lookup instance.
//   clk_i     clock
//   reset_i   asynchronous active-low reset
//   bus       fwd_scoreboard_if.slave: issue info, operand inputs, forwarded
//             operands, hit flags, stall request and saturating stall count
// -----------------------------------------------------------------------------
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RA_W  = RA_W_DEF,
  parameter int DEPTH = 3,
  parameter int NSRC  = 2,
  parameter int CNT_W = 16
) (
  input logic             clk_i,
  input logic             reset_i,
  fwd_scoreboard_if.slave bus
);

  // Same layout as fwd_pkg::entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic            vld;
    logic [RA_W-1:0] rd;
    logic            ld;
    logic [XLEN-1:0] data;
  } slot_t;

  slot_t                     r_ent [DEPTH];
  slot_t                     w_nxt [DEPTH];
  logic [CNT_W-1:0]          r_cnt;

  logic [DEPTH-1:0]          w_vld;
  logic [DEPTH*RA_W-1:0]     w_rd;
  logic [1:0]                w_ld;
  logic [(DEPTH-1)*XLEN-1:0] w_data;
  logic [NSRC*XLEN-1:0]      w_opnd;
  logic [NSRC-1:0]           w_hit;
  logic [NSRC-1:0]           w_src_stall;
  logic                      w_stall;

  // Flatten the entries for the lookup instances.
  always_comb begin
    w_vld  = '0;
    w_rd   = '0;
    w_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_vld[k]               = r_ent[k].vld;
      w_rd[k*RA_W +: RA_W]   = r_ent[k].rd;
    end
    for (int k = 1; k < DEPTH; k++) begin
      w_data[(k-1)*XLEN +: XLEN] = r_ent[k].data;
    end
  end

  assign w_ld = {r_ent[1].ld, r_ent[0].ld};

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    fwd_lookup #(
      .XLEN  (XLEN),
      .RA_W  (RA_W),
      .DEPTH (DEPTH)
    ) u_lookup (
      .i_rs         (bus.rs_i[s*RA_W +: RA_W]),
      .i_rf_data    (bus.rf_data_i[s*XLEN +: XLEN]),
      .i_alu_result (bus.alu_result_i),
      .i_mem_rdata  (bus.mem_rdata_i),
      .i_vld        (w_vld),
      .i_rd         (w_rd),
      .i_ld         (w_ld),
      .i_data       (w_data),
      .o_opnd       (w_opnd[s*XLEN +: XLEN]),
      .o_hit        (w_hit[s]),
      .o_stall      (w_src_stall[s])
    );
  end

  // Outputs are forced quiet while reset is held.
  assign w_stall         = reset_i && bus.issue_valid_i && (|w_src_stall);
  assign bus.stall_o     = w_stall;
  assign bus.opnd_o      = reset_i ? w_opnd : '0;
  assign bus.fwd_hit_o   = reset_i ? w_hit  : '0;
  assign bus.stall_cnt_o = r_cnt;

  // Next scoreboard contents for a non-held cycle.
  always_comb begin
    w_nxt[0] = '0;
    if (bus.issue_valid_i && !bus.flush_i && !w_stall) begin
      w_nxt[0].vld = bus.issue_we_i;
      w_nxt[0].rd  = bus.issue_rd_i;
      w_nxt[0].ld  = bus.issue_is_load_i;
    end
    // Leaving EX: capture the ALU result (loads are overwritten one step later).
    w_nxt[1]      = r_ent[0];
    w_nxt[1].data = bus.alu_result_i;
    for (int k = 2; k < DEPTH; k++) begin
      w_nxt[k] = r_ent[k-1];
      // Leaving MEM: a load picks up its memory data here.
      if ((k == 2) && r_ent[1].ld) w_nxt[k].data = bus.mem_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      // NOTE: the entries are a handful of flops, not a RAM, so each one is
      // cleared by the async reset and in-flight writes vanish at once.
      for (int k = 0; k < DEPTH; k++) r_ent[k] <= '0;
      r_cnt <= '0;
    end else if (!bus.hold_i) begin
      // NOTE: state updates use non-blocking assignments so every entry
      // shifts from its pre-edge neighbour regardless of statement order.
      for (int k = 0; k < DEPTH; k++) r_ent[k] <= w_nxt[k];
      if (w_stall && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_fwd_scoreboard
// Scoreboard bench for fwd_scoreboard. The driver applies one instruction's
// worth of inputs per cycle and pushes the reference model's expectation;
// a monitor on the falling edge pops and compares. A second DUT with a
// 2-bit stall counter shares the same stimulus to exercise saturation.
// -----------------------------------------------------------------------------
module tb_fwd_scoreboard;
  import fwd_pkg::*;

  localparam int XLEN  = 32;
  localparam int RA_W  = 5;
  localparam int DEPTH = 3;
  localparam int NSRC  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fwd_scoreboard_if #(.XLEN(XLEN), .RA_W(RA_W), .NSRC(NSRC), .CNT_W(16)) bus ();
  fwd_scoreboard_if #(.XLEN(XLEN), .RA_W(RA_W), .NSRC(NSRC), .CNT_W(2))  bus_s ();

  assign bus_s.hold_i          = bus.hold_i;
  assign bus_s.flush_i         = bus.flush_i;
  assign bus_s.issue_valid_i   = bus.issue_valid_i;
  assign bus_s.issue_rd_i      = bus.issue_rd_i;
  assign bus_s.issue_we_i      = bus.issue_we_i;
  assign bus_s.issue_is_load_i = bus.issue_is_load_i;
  assign bus_s.rs_i            = bus.rs_i;
  assign bus_s.rf_data_i       = bus.rf_data_i;
  assign bus_s.alu_result_i    = bus.alu_result_i;
  assign bus_s.mem_rdata_i     = bus.mem_rdata_i;

  fwd_scoreboard #(.XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH), .NSRC(NSRC), .CNT_W(16)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  fwd_scoreboard #(.XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH), .NSRC(NSRC), .CNT_W(2)) dut_sat (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus_s)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // pipe[0] is the instruction in EX, pipe[i] is i stages older.
  entry_t pipe[$];
  int     m_cnt;
  int     m_cnt_s;
  bit     m_stall;

  typedef struct {
    string       tag;
    logic [63:0] opnd;
    logic [1:0]  hit;
    logic        stall;
    logic [15:0] cnt;
    logic [1:0]  cnt_s;
  } exp_t;
  exp_t exp_q[$];

  task automatic model_clear();
    entry_t z;
    z = '0;
    pipe.delete();
    for (int i = 0; i < DEPTH; i++) pipe.push_back(z);
    m_cnt   = 0;
    m_cnt_s = 0;
    m_stall = 1'b0;
  endtask

  // Value of the youngest in-flight writer of rs, as the pipeline sees it now.
  task automatic model_lookup(input logic [4:0] rs, input logic [31:0] rf, input logic [31:0] alu,
                              input logic [31:0] mem, output logic [31:0] v, output bit hit,
                              output bit st);
    bit done;
    v    = rf;
    hit  = 1'b0;
    st   = 1'b0;
    done = 1'b0;
    if (rs != 5'd0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!done && pipe[i].vld && pipe[i].rd == rs) begin
          done = 1'b1;
          if (i == 0 && pipe[i].ld) begin
            st = 1'b1;
          end else begin
            hit = 1'b1;
            if (i == 0)                 v = alu;
            else if (i == 1 && pipe[i].ld) v = mem;
            else                        v = pipe[i].data;
          end
        end
      end
    end
  endtask

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic model_step();
    entry_t nw;
    if (!rst_n || bus.hold_i) return;
    if (m_stall) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt_s < 3)   m_cnt_s++;
    end
    nw     = '0;
    nw.vld = bus.issue_valid_i && !bus.flush_i && !m_stall && bus.issue_we_i;
    nw.rd  = bus.issue_rd_i;
    nw.ld  = bus.issue_is_load_i;
    pipe[0].data = bus.alu_result_i;
    if (pipe[1].ld) pipe[1].data = bus.mem_rdata_i;
    pipe.push_front(nw);
    void'(pipe.pop_back());
  endtask

  // ---------------- driver ----------------
  task automatic apply(input bit valid, input bit we, input bit ld, input logic [4:0] rd,
                       input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [31:0] rf0, input logic [31:0] rf1,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input bit hold, input bit flush, input string tag);
    logic [31:0] v0, v1;
    bit          h0, h1, s0, s1;
    exp_t        e;
    bus.issue_valid_i   = valid;
    bus.issue_we_i      = we;
    bus.issue_is_load_i = ld;
    bus.issue_rd_i      = rd;
    bus.rs_i            = {rs1, rs0};
    bus.rf_data_i       = {rf1, rf0};
    bus.alu_result_i    = alu;
    bus.mem_rdata_i     = mem;
    bus.hold_i          = hold;
    bus.flush_i         = flush;
    model_lookup(rs0, rf0, alu, mem, v0, h0, s0);
    model_lookup(rs1, rf1, alu, mem, v1, h1, s1);
    m_stall = valid && (s0 || s1);
    e.tag   = tag;
    e.opnd  = {v1, v0};
    e.hit   = {h1, h0};
    e.stall = m_stall;
    e.cnt   = 16'(m_cnt);
    e.cnt_s = 2'(m_cnt_s);
    exp_q.push_back(e);
  endtask

  task automatic push_zero(input string tag);
    exp_t e;
    e.tag   = tag;
    e.opnd  = '0;
    e.hit   = '0;
    e.stall = 1'b0;
    e.cnt   = '0;
    e.cnt_s = '0;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic peek();
    @(negedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({e.tag, "_opnd"},  bus.opnd_o,        e.opnd);
      check({e.tag, "_hit"},   bus.fwd_hit_o,     e.hit);
      check({e.tag, "_stall"}, bus.stall_o,       e.stall);
      check({e.tag, "_cnt"},   bus.stall_cnt_o,   e.cnt);
      check({e.tag, "_cnt2"},  bus_s.stall_cnt_o, e.cnt_s);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.issue_valid_i   = 1'b0;
    bus.issue_we_i      = 1'b0;
    bus.issue_is_load_i = 1'b0;
    bus.issue_rd_i      = '0;
    bus.rs_i            = '0;
    bus.rf_data_i       = '0;
    bus.alu_result_i    = '0;
    bus.mem_rdata_i     = '0;
    bus.hold_i          = 1'b0;
    bus.flush_i         = 1'b0;
    model_clear();

    // Reset state: outputs quiet even with live inputs.
    @(posedge clk);
    #1;
    bus.issue_valid_i = 1'b1;
    bus.rs_i          = {5'd4, 5'd5};
    bus.rf_data_i     = {32'h2222, 32'h1111};
    push_zero("reset");
    peek();
    check("reset_opnd_lit", bus.opnd_o, 64'h0);
    step();
    rst_n = 1'b1;

    // Back-to-back ALU RAW.
    apply(1, 1, 0, 5'd5, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, "raw_issue");
    step();
    apply(1, 0, 0, 5'd0, 5'd5, 5'd0, 32'h100, 32'h200, 32'h11, 32'h0, 0, 0, "raw_use");
    peek();
    check("raw_opnd0_lit", bus.opnd_o[31:0], 32'h11);
    check("raw_hit_lit", bus.fwd_hit_o, 2'b01);
    step();

    // Load-use: one stall cycle, then memory data forwarded from MEM.
    apply(1, 1, 1, 5'd7, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, "lu_issue");
    step();
    apply(1, 0, 0, 5'd0, 5'd0, 5'd7, 32'h300, 32'h400, 32'h55, 32'h0, 0, 0, "lu_stall");
    peek();
    check("lu_stall_lit", bus.stall_o, 1'b1);
    step();
    apply(1, 0, 0, 5'd0, 5'd0, 5'd7, 32'h300, 32'h400, 32'h55, 32'hDEADBEEF, 0, 0, "lu_fwd");
    peek();
    check("lu_opnd1_lit", bus.opnd_o[63:32], 32'hDEADBEEF);
    check("lu_stall_clear_lit", bus.stall_o, 1'b0);
    check("lu_cnt_lit", bus.stall_cnt_o, 16'd1);
    step();

    // Priority: x3 at E2 = 0xAA, x3 at E1 = 0xBB -> youngest wins.
    apply(1, 1, 0, 5'd3, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, "pri_a");
    step();
    apply(1, 1, 0, 5'd3, 5'd0, 5'd0, 32'h0, 32'h0, 32'hAA, 32'h0, 0, 0, "pri_b");
    step();
    apply(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'hBB, 32'h0, 0, 0, "pri_c");
    step();
    apply(1, 0, 0, 5'd0, 5'd3, 5'd3, 32'h1, 32'h2, 32'hCC, 32'hDD, 0, 0, "pri_use");
    peek();
    check("pri_opnd_lit", bus.opnd_o, {32'hBB, 32'hBB});
    step();

    // x0 destination never forwards.
    apply(1, 1, 0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, "x0_issue");
    step();
    apply(1, 0, 0, 5'd0, 5'd0, 5'd0, 32'h77, 32'h88, 32'h99, 32'h0, 0, 0, "x0_use");
    peek();
    check("x0_opnd_lit", bus.opnd_o, {32'h88, 32'h77});
    check("x0_hit_lit", bus.fwd_hit_o, 2'b00);
    step();

    // Hold with a load in MEM: operand follows mem_rdata, nothing shifts.
    apply(1, 1, 1, 5'd9, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, "hold_ld");
    step();
    apply(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, "hold_bub");
    step();
    apply(1, 0, 0, 5'd0, 5'd9, 5'd0, 32'h5, 32'h6, 32'h0, 32'h1, 1, 0, "hold1");
    step();
    apply(1, 0, 0, 5'd0, 5'd9, 5'd0, 32'h5, 32'h6, 32'h0, 32'h2, 1, 0, "hold2");
    peek();
    check("hold_opnd_lit", bus.opnd_o[31:0], 32'h2);
    step();
    apply(1, 0, 0, 5'd0, 5'd9, 5'd0, 32'h5, 32'h6, 32'h0, 32'h2, 1, 0, "hold3");
    step();
    apply(1, 0, 0, 5'd0, 5'd9, 5'd0, 32'h5, 32'h6, 32'h0, 32'h2, 0, 0, "hold_rel");
    step();
    apply(1, 0, 0, 5'd0, 5'd9, 5'd0, 32'h5, 32'h6, 32'h0, 32'h999, 0, 0, "hold_e2");
    peek();
    check("hold_e2_lit", bus.opnd_o[31:0], 32'h2);
    check("hold_cnt_lit", bus.stall_cnt_o, 16'd1);
    step();

    // Hold together with a stall: stall stays up, counter frozen.
    apply(1, 1, 1, 5'd10, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, "hs_ld");
    step();
    apply(1, 0, 0, 5'd0, 5'd0, 5'd10, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, "hs_held");
    step();
    apply(1, 0, 0, 5'd0, 5'd0, 5'd10, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, "hs_rel");
    step();
    apply(1, 0, 0, 5'd0, 5'd0, 5'd10, 32'h0, 32'h0, 32'h0, 32'h4242, 0, 0, "hs_fwd");
    step();

    // Flush kills the issuing instruction.
    apply(1, 1, 0, 5'd11, 5'd0, 5'd0, 32'h0, 32'h0, 32'h5, 32'h0, 0, 1, "fl_issue");
    step();
    apply(1, 0, 0, 5'd0, 5'd11, 5'd0, 32'hF00, 32'h0, 32'h5, 32'h0, 0, 0, "fl_use");
    peek();
    check("fl_opnd_lit", bus.opnd_o[31:0], 32'hF00);
    check("fl_hit_lit", bus.fwd_hit_o, 2'b00);
    step();

    // Five more stalls: 2-bit counter pins at 3.
    for (int i = 0; i < 5; i++) begin
      apply(1, 1, 1, 5'd12, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, "sat_ld");
      step();
      apply(1, 0, 0, 5'd0, 5'd12, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, "sat_stall");
      step();
    end
    apply(1, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, "sat_end");
    peek();
    check("sat_cnt2_lit", bus_s.stall_cnt_o, 2'd3);
    check("sat_cnt16_lit", bus.stall_cnt_o, 16'd7);
    step();

    // Async reset between edges with x13 in flight.
    apply(1, 1, 0, 5'd13, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, "rm_issue");
    step();
    apply(1, 0, 0, 5'd0, 5'd13, 5'd0, 32'hABC, 32'h0, 32'h31, 32'h0, 0, 0, "rm_pre");
    step();
    bus.rs_i      = {5'd0, 5'd13};
    bus.rf_data_i = {32'h0, 32'hABC};
    #2;
    rst_n = 1'b0;
    model_clear();
    push_zero("rm_in_reset");
    #1;
    check("rm_opnd_lit", bus.opnd_o, 64'h0);
    check("rm_stall_lit", bus.stall_o, 1'b0);
    step();
    rst_n = 1'b1;
    apply(1, 0, 0, 5'd0, 5'd13, 5'd0, 32'hABC, 32'h0, 32'h31, 32'h0, 0, 0, "rm_post");
    peek();
    check("rm_post_opnd_lit", bus.opnd_o[31:0], 32'hABC);
    check("rm_post_hit_lit", bus.fwd_hit_o, 2'b00);
    step();

    // Randomised traffic over a small register set to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      apply(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom, $urandom, $urandom, $urandom,
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0), "rand");
      step();
    end

    peek();
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the RISC-V pipeline.
- Tracks every in-flight register write from EX through the last writeback stage in an internal shift-register scoreboard.
- Selects, per source operand, the youngest producer's value, or the register-file value if there is no producer.
- Raises a load-use stall when a value is not yet available.
- Sits between ID/EX operand read and the ALU; keeps a saturating stall-cycle counter.

Parameters:
- XLEN, 32, data width.
- RA_W, 5, register address width.
- DEPTH, 3, in-flight entries tracked (E0=EX, E1=MEM, E2..=WB and later); must be >= 2.
- NSRC, 2, number of source operands checked.
- CNT_W, 16, stall counter width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-low reset.
- hold_i  in  1  global freeze (memory wait); scoreboard does not shift.
- flush_i  in  1  kill the instruction entering EX this cycle (branch taken).
- issue_valid_i  in  1  ID stage holds a real instruction.
- issue_rd_i  in  RA_W  its destination register.
- issue_we_i  in  1  it writes rd.
- issue_is_load_i  in  1  it is a load.
- rs_i  in  NSRC*RA_W  source register addresses, packed.
- rf_data_i  in  NSRC*XLEN  register-file read data, packed.
- alu_result_i  in  XLEN  result of the instruction currently in E0.
- mem_rdata_i  in  XLEN  load data of the instruction currently in E1.
- opnd_o  out  NSRC*XLEN  forwarded operands.
- fwd_hit_o  out  NSRC  operand s was taken from the scoreboard.
- stall_o  out  1  load-use stall request to IF/ID.
- stall_cnt_o  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Entry fields: vld, rd, ld (is load), data (XLEN).
- Reset (reset_i=0, asynchronous):
  - all entries vld=0, rd=0, ld=0, data=0;
  - stall_cnt_o=0;
  - while held in reset, opnd_o=0, fwd_hit_o=0, stall_o=0.
- Lookup for source s (combinational):
  - If rs==0: opnd=rf_data, no hit, no stall contribution.
  - Otherwise scan E0, E1, ..., E[DEPTH-1]; the first (youngest) entry with vld and rd==rs wins.
  - Winner E0, ld=0: opnd=alu_result_i.
  - Winner E0, ld=1: stall contribution; opnd=rf_data.
  - Winner E1, ld=1: opnd=mem_rdata_i.
  - Winner E1, ld=0, or any Ek with k>=2: opnd=Ek.data.
  - No winner: opnd=rf_data, fwd_hit=0.
  - fwd_hit_o[s]=1 only for a winner that does not stall.
- stall_o = OR of the per-source stall contributions, gated by issue_valid_i.
- Shift (posedge, when hold_i=0):
  - E0 is loaded with a bubble (vld=0) if stall_o, flush_i or !issue_valid_i. Otherwise E0 gets vld=issue_we_i, rd=issue_rd_i, ld=issue_is_load_i.
  - E1 <= E0, with data=alu_result_i. Load data is not captured at this step.
  - E2 <= E1, with data=mem_rdata_i if E1.ld, else E1.data.
  - Ek <= Ek-1 for k>=3, data unchanged.
  - The oldest entry retires.
- Boundary and simultaneous-event rules:
  - hold_i=1: all entries frozen. Lookup stays live, so operands track the current alu_result_i and mem_rdata_i.
  - hold_i=1 and stall_o=1: nothing shifts; stall_o stays asserted.
  - flush_i and stall_o together: bubble inserted, which is the same outcome as either alone.
  - Two entries with the same rd: the youngest always wins.
  - rd==0 entries may be stored but never match.
- Stall counter: increments by 1 on each posedge with stall_o=1 and hold_i=0. Saturates at 2^CNT_W-1; it does not wrap.
- Reset asserted mid-operation: all in-flight entries are dropped immediately, with no partial shift.
- Latency: forwarding is zero-cycle combinational; the scoreboard updates 1 cycle after issue.

Decomposition:
- Shared package fwd_pkg:
  - entry struct (vld, rd, ld, data);
  - source-select encoding constants (RF, ALU, MEM, ENTRY);
  - default XLEN/RA_W.
- Sub-module fwd_lookup: one instance per source (generate loop over NSRC). Pure combinational priority scan returning opnd, hit and stall.
- The top holds the entry registers, the shift logic and the counter.

Test Plan:
- Back-to-back ALU RAW: issue x5 write, alu_result_i=0x11; next cycle rs1=5 -> opnd0=0x11, fwd_hit_o=01, stall_o=0.
- Load-use: load to x7, next instruction rs2=7 -> stall_o=1 for exactly one cycle and stall_cnt_o=1. Following cycle, with mem_rdata_i=0xDEADBEEF -> opnd1=0xDEADBEEF.
- Priority: x3 written at E2 with 0xAA and at E1 with 0xBB, rs1=rs2=3 -> both operands 0xBB. x0 destination with rs=0 -> rf_data_i passed through, no hit.
- hold_i for 3 cycles with a load in E1 -> no shift, stall_cnt_o unchanged. mem_rdata_i changing 0x1 to 0x2 -> opnd follows it. Release -> E2.data=0x2.
- flush_i with a valid issue to x9 -> next cycle rs1=9 takes rf_data_i, fwd_hit_o=0. Saturation: CNT_W=2, force 5 stalls -> stall_cnt_o=3.
- Async reset asserted mid-pipeline, between clock edges -> entries cleared immediately, opnd_o=0, stall_o=0. After release -> no stale hits.
